pwm_fade_ctrl: RTL and testbench
================================

# pwm_fade_ctrl

Multi-channel duty-cycle sequencer that sits in front of a bank of 8-bit PWM generators. It accepts ramp commands (channel, target duty, step rate) over a valid/ready handshake and moves each channel's duty value one LSB at a time toward its target, paced by a shared programmable prescaler. The `duty` outputs feed the `value` inputs of the PWM generators directly; software on the Nios II side issues fades without touching duty registers cycle by cycle.

## Interface
- `NCH`, 4: number of channels, range 1..8.
- `DIV_W`, 16: width of the prescaler divisor.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `tick_div`  in  DIV_W  prescaler divisor; one tick every `tick_div`+1 cycles.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command can be accepted.
- `cmd_ch`  in  3  target channel; only the low bits up to `NCH`-1 are used.
- `cmd_target`  in  8  requested final duty.
- `cmd_rate`  in  8  ticks per one-LSB step; 0 means jump immediately.
- `duty`  out  NCH*8  per-channel duty; channel i is at bits [8i+7:8i].
- `busy`  out  NCH  channel i is ramping.
- `done`  out  NCH  one-cycle pulse when channel i reaches its target.

## Operation
- Reset, sampled at the clock edge: `duty`=0, `busy`=0, `done`=0, `cmd_ready`=0, prescaler count=0, every channel in IDLE. `cmd_ready` goes to 1 on the first edge with `rst`=0. Reset mid-ramp aborts all ramps, with no `done` pulse.
- Prescaler: counter `pcnt`. `tick`=(`pcnt` >= `tick_div`). On a tick `pcnt` returns to 0; otherwise it increments. With `tick_div`=0 a tick occurs every cycle. Lowering `tick_div` below `pcnt` produces a tick on the next cycle.
- Handshake: a command is accepted on an edge where `cmd_valid`=1 and `cmd_ready`=1. `cmd_ready` stays 1 outside reset, so the block sustains one command per cycle. A `cmd_ch` >= `NCH` is accepted and ignored.
- Per-channel registers: `tgt`[7:0], `rate`[7:0], `rcnt`[7:0], state.
- State IDLE:
  - Accept with `cmd_rate`=0, or with `cmd_target` equal to the current duty: set `duty`=`cmd_target` and pulse `done`; stay IDLE.
  - Accept otherwise: load `tgt` and `rate`, set `rcnt`=`cmd_rate`, go to RAMP.
- State RAMP:
  - On a tick with `rcnt`>1: `rcnt`-1.
  - On a tick with `rcnt`=1: duty moves ±1 toward `tgt` and `rcnt` reloads from `rate`. If the new duty equals `tgt`, go to IDLE and pulse `done`.
- Retarget during RAMP: a new command for the same channel replaces `tgt` and `rate` and reloads `rcnt`. Duty continues from its current value with no `done` for the old target. The zero-rate and equal-target rules apply as in IDLE.
- Simultaneous tick and accepted command on the same channel: the command wins and that tick is ignored for that channel. Other channels still process the tick.
- Width rules:
  - Duty steps never wrap; direction comes from an unsigned compare of duty against `tgt`.
  - `duty` holds any value from 0 through 255.
- Outputs:
  - `busy`[i] = (state==RAMP).
  - `done`[i] is registered, high for exactly one cycle, in the same cycle duty first equals the target.

## Timing
- Command latency: accepted on edge N.
  - `busy` is 1 from edge N.
  - With `cmd_rate`=0, `duty`=target and `done`=1 from edge N.
- Ramp latency:
  - The first step occurs on the edge of the R-th tick after edge N, where R=`cmd_rate`.
  - Each later step follows R ticks after the previous one.
  - Total ramp time is |target − start| × R ticks.
- With `tick_div`=D, ticks fall on every (D+1)-th edge, counted from reset release.
- `done` and the final duty update share the same edge. `busy` falls on that edge.
- No combinational path from command inputs to outputs; `cmd_ready` is registered.

## Test plan
- Reset mid-ramp: ch0 ramping 0→200. Assert `rst` for 1 cycle → `duty`=0, `busy`=0, no `done`, and `cmd_ready`=0 for that cycle and 1 the cycle after.
- Basic ramp: `tick_div`=0; ch1, target 4, rate 1 → duty 1,2,3,4 on edges N+1..N+4; `done`[1] pulses at N+4; `busy`[1] high for N..N+3.
- Prescaled down-ramp: ch2 preset to 10; `tick_div`=3; target 8, rate 2 → one step every 8 cycles; duty reaches 8 after 16 cycles with a single `done` pulse.
- Jump and equal-target cases:
  - ch3 at 50; rate 0, target 255 → duty 255 on the accept edge plus `done`.
  - Then target 255, rate 5 → immediate `done`, `busy` stays 0.
- Retarget collision: ch0 ramping up at rate 1, `tick_div`=0. Issue target 3 when duty=6 → that cycle's step is dropped; duty goes 5,4,3; exactly one `done`, none for the original target.
- Concurrency: all 4 channels commanded on consecutive cycles with rates 1..4, plus `cmd_ch`=7 → each channel steps independently at its own rate; the channel-7 command has no effect.

Source files
------------

// File: rtl/pwm_fade_ctrl.sv
// ============================================================================
// Module      : pwm_fade_ctrl
// Description : Multi-channel duty-cycle fade sequencer for 8-bit PWM banks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_fade_ctrl #(
    parameter int NCH   = 4,
    parameter int DIV_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_W-1:0]     tick_div,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_ch,
    input  logic [7:0]           cmd_target,
    input  logic [7:0]           cmd_rate,
    output logic [NCH*8-1:0]     duty,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       done
);

    localparam logic [0:0]       c_st_idle = 1'b0;
    localparam logic [0:0]       c_st_ramp = 1'b1;
    localparam logic [DIV_W-1:0] c_pcnt_one = {{(DIV_W-1){1'b0}}, 1'b1};

    logic             r_cmd_ready;
    logic [DIV_W-1:0] r_pcnt;
    logic             w_tick;
    logic             w_accept;

    assign w_tick    = (r_pcnt >= tick_div);
    assign w_accept  = cmd_valid && r_cmd_ready;
    assign cmd_ready = r_cmd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_ready <= 1'b0;
            r_pcnt      <= '0;
        end else begin
            r_cmd_ready <= 1'b1;
            r_pcnt      <= w_tick ? '0 : r_pcnt + c_pcnt_one;
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        localparam logic [2:0] c_idx = 3'(gi);

        logic [7:0] r_duty;
        logic [7:0] r_tgt;
        logic [7:0] r_rate;
        logic [7:0] r_rcnt;
        logic [0:0] r_state;
        logic       r_done;
        logic       w_hit;
        logic       w_jump;
        logic [7:0] w_next;

        assign w_hit  = w_accept && (cmd_ch == c_idx);
        assign w_jump = (cmd_rate == 8'd0) || (cmd_target == r_duty);
        // Direction from an unsigned compare; the ramp stops at tgt so it never wraps.
        assign w_next = (r_duty < r_tgt) ? r_duty + 8'd1 : r_duty - 8'd1;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_duty  <= 8'd0;
                r_tgt   <= 8'd0;
                r_rate  <= 8'd0;
                r_rcnt  <= 8'd0;
                r_state <= c_st_idle;
                r_done  <= 1'b0;
            end else begin
                r_done <= 1'b0;
                if (w_hit) begin
                    // A command always beats a coincident tick on its own channel.
                    if (w_jump) begin
                        r_duty  <= cmd_target;
                        r_done  <= 1'b1;
                        r_state <= c_st_idle;
                    end else begin
                        r_tgt   <= cmd_target;
                        r_rate  <= cmd_rate;
                        r_rcnt  <= cmd_rate;
                        r_state <= c_st_ramp;
                    end
                end else if (r_state == c_st_ramp && w_tick) begin
                    if (r_rcnt > 8'd1) begin
                        r_rcnt <= r_rcnt - 8'd1;
                    end else begin
                        r_duty <= w_next;
                        r_rcnt <= r_rate;
                        if (w_next == r_tgt) begin
                            r_state <= c_st_idle;
                            r_done  <= 1'b1;
                        end
                    end
                end
            end
        end

        assign duty[gi*8 +: 8] = r_duty;
        assign busy[gi]        = (r_state == c_st_ramp);
        assign done[gi]        = r_done;
    end

endmodule

`default_nettype wire

// File: tb/tb_pwm_fade_ctrl.sv
// ============================================================================
// Module      : tb_pwm_fade_ctrl
// Description : Directed vector bench for pwm_fade_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_fade_ctrl;

    localparam int NCH   = 4;
    localparam int DIV_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [DIV_W-1:0] tick_div;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_ch;
    logic [7:0]       cmd_target;
    logic [7:0]       cmd_rate;
    logic [NCH*8-1:0] duty;
    logic [NCH-1:0]   busy;
    logic [NCH-1:0]   done;

    int checks   = 0;
    int failures = 0;

    pwm_fade_ctrl #(.NCH(NCH), .DIV_W(DIV_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_div   (tick_div),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_ch     (cmd_ch),
        .cmd_target (cmd_target),
        .cmd_rate   (cmd_rate),
        .duty       (duty),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        v;
        logic [2:0]  ch;
        logic [7:0]  tgt;
        logic [7:0]  rate;
        logic [31:0] e_duty;
        logic [3:0]  e_busy;
        logic [3:0]  e_done;
        logic        e_ready;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply inputs, clock one edge, settle just after the edge.
    task automatic drive(input logic r, input logic v, input logic [2:0] ch,
                         input logic [7:0] t, input logic [7:0] rt);
        rst        = r;
        cmd_valid  = v;
        cmd_ch     = ch;
        cmd_target = t;
        cmd_rate   = rt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int done_cnt;
        rst        = 1'b1;
        tick_div   = '0;
        cmd_valid  = 1'b0;
        cmd_ch     = '0;
        cmd_target = '0;
        cmd_rate   = '0;

        vecs[0]  = '{1'b1, 1'b0, 3'd0, 8'd0,   8'd0, 32'h00000000, 4'b0000, 4'b0000, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 3'd0, 8'd0,   8'd0, 32'h00000000, 4'b0000, 4'b0000, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 3'd1, 8'd4,   8'd1, 32'h00000000, 4'b0010, 4'b0000, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 3'd0, 8'd0,   8'd0, 32'h00000100, 4'b0010, 4'b0000, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 3'd0, 8'd0,   8'd0, 32'h00000200, 4'b0010, 4'b0000, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 3'd0, 8'd0,   8'd0, 32'h00000300, 4'b0010, 4'b0000, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 3'd0, 8'd0,   8'd0, 32'h00000400, 4'b0000, 4'b0010, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 3'd0, 8'd0,   8'd0, 32'h00000400, 4'b0000, 4'b0000, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 3'd3, 8'd50,  8'd0, 32'h32000400, 4'b0000, 4'b1000, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 3'd3, 8'd255, 8'd0, 32'hFF000400, 4'b0000, 4'b1000, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 3'd3, 8'd255, 8'd5, 32'hFF000400, 4'b0000, 4'b1000, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 3'd7, 8'd99,  8'd0, 32'hFF000400, 4'b0000, 4'b0000, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 3'd2, 8'd0,   8'd3, 32'hFF000400, 4'b0000, 4'b0100, 1'b1};

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rst, vecs[i].v, vecs[i].ch, vecs[i].tgt, vecs[i].rate);
            check($sformatf("vec%0d_duty", i),  duty,              vecs[i].e_duty);
            check($sformatf("vec%0d_busy", i),  32'(busy),         32'(vecs[i].e_busy));
            check($sformatf("vec%0d_done", i),  32'(done),         32'(vecs[i].e_done));
            check($sformatf("vec%0d_ready", i), 32'(cmd_ready),    32'(vecs[i].e_ready));
        end

        // Prescaled down-ramp on ch2: preset 10, then target 8 at rate 2 with tick_div 3.
        drive(1'b0, 1'b1, 3'd2, 8'd10, 8'd0);
        check("pre_duty2", 32'(duty[23:16]), 32'd10);
        check("pre_done2", 32'(done[2]), 32'd1);
        tick_div = 16'd3;
        drive(1'b0, 1'b1, 3'd2, 8'd8, 8'd2);
        check("down_k0_duty2", 32'(duty[23:16]), 32'd10);
        check("down_k0_busy2", 32'(busy[2]), 32'd1);
        done_cnt = 0;
        for (int k = 1; k <= 18; k++) begin
            drive(1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
            if (done[2]) done_cnt++;
            check($sformatf("down_k%0d_duty2", k), 32'(duty[23:16]),
                  (k < 7) ? 32'd10 : ((k < 15) ? 32'd9 : 32'd8));
            check($sformatf("down_k%0d_busy2", k), 32'(busy[2]), (k < 15) ? 32'd1 : 32'd0);
            check($sformatf("down_k%0d_done2", k), 32'(done[2]), (k == 15) ? 32'd1 : 32'd0);
        end
        check("down_done_count", 32'(done_cnt), 32'd1);
        tick_div = 16'd0;
        drive(1'b0, 1'b0, 3'd0, 8'd0, 8'd0);

        // Retarget collision on ch0: ramp toward 200, retarget to 3 at duty 6.
        done_cnt = 0;
        drive(1'b0, 1'b1, 3'd0, 8'd200, 8'd1);
        check("rt_k0_duty0", 32'(duty[7:0]), 32'd0);
        check("rt_k0_busy0", 32'(busy[0]), 32'd1);
        for (int k = 1; k <= 6; k++) begin
            drive(1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
            if (done[0]) done_cnt++;
            check($sformatf("rt_k%0d_duty0", k), 32'(duty[7:0]), 32'(k));
        end
        drive(1'b0, 1'b1, 3'd0, 8'd3, 8'd1);
        if (done[0]) done_cnt++;
        check("rt_hit_duty0", 32'(duty[7:0]), 32'd6);
        check("rt_hit_busy0", 32'(busy[0]), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            drive(1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
            if (done[0]) done_cnt++;
            check($sformatf("rt_down%0d_duty0", k), 32'(duty[7:0]), (k < 3) ? 32'(6 - k) : 32'd3);
            check($sformatf("rt_down%0d_done0", k), 32'(done[0]), (k == 3) ? 32'd1 : 32'd0);
            check($sformatf("rt_down%0d_busy0", k), 32'(busy[0]), (k < 3) ? 32'd1 : 32'd0);
        end
        check("rt_done_count", 32'(done_cnt), 32'd1);

        // Reset mid-ramp.
        drive(1'b0, 1'b1, 3'd0, 8'd200, 8'd1);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
        check("mid_busy_before", 32'(busy[0]), 32'd1);
        drive(1'b1, 1'b0, 3'd0, 8'd0, 8'd0);
        check("rst_duty",  duty,           32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_done",  32'(done),      32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd0);
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
            check($sformatf("post%0d_duty", k),  duty,           32'd0);
            check($sformatf("post%0d_busy", k),  32'(busy),      32'd0);
            check($sformatf("post%0d_done", k),  32'(done),      32'd0);
            check($sformatf("post%0d_ready", k), 32'(cmd_ready), 32'd1);
        end

        // Concurrency: channel c accepted at edge c with rate c+1 toward 3; then an ignored ch7.
        for (int e = 0; e <= 18; e++) begin
            logic [31:0] exp_duty;
            logic [3:0]  exp_busy;
            logic [3:0]  exp_done;
            if (e <= 3)      drive(1'b0, 1'b1, 3'(e), 8'd3, 8'(e + 1));
            else if (e == 4) drive(1'b0, 1'b1, 3'd7, 8'd9, 8'd0);
            else             drive(1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
            exp_duty = '0;
            exp_busy = '0;
            exp_done = '0;
            for (int c = 0; c < 4; c++) begin
                int n;
                n = (e >= c) ? (e - c) / (c + 1) : 0;
                if (n > 3) n = 3;
                exp_duty[c*8 +: 8] = 8'(n);
                exp_busy[c] = (e >= c) && (n < 3);
                exp_done[c] = (e == c + 3 * (c + 1));
            end
            check($sformatf("conc_e%0d_duty", e), duty,       exp_duty);
            check($sformatf("conc_e%0d_busy", e), 32'(busy), 32'(exp_busy));
            check($sformatf("conc_e%0d_done", e), 32'(done), 32'(exp_done));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
